router_packet_assembler: RTL and testbench

Downstream consumer of an inter-board receive FIFO (the `routerDCFIFO` written by `interboard_input`). It pops 11-bit flits, each carrying a 10-bit payload in [9:0] and a tail flag in [10], and assembles them into one wide packet word. It presents the word on a valid/ready port to local logic (decoder or host bridge). Packets longer than `MAX_FLITS` are truncated and flagged.

---
 rtl/router_pkg.sv | 14 +
 rtl/router_sat_counter.sv | 17 +
 rtl/router_packet_assembler.sv | 114 +++++++++++
 tb/tb_router_packet_assembler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared flit format and assembler state encoding for the router receive path.
package router_pkg;

    localparam int FLIT_W    = 11;
    localparam int PAYLOAD_W = FLIT_W - 1;
    localparam int TAIL_BIT  = FLIT_W - 1;

    typedef enum logic [1:0] {
        COLLECT,
        DROP,
        HOLD
    } asm_state_t;

endpackage

// File: rtl/router_sat_counter.sv
// 16-bit event counter that sticks at all-ones instead of wrapping; sync clear.
module router_sat_counter (
    input  logic        clk,
    input  logic        clear,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= 16'd0;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/router_packet_assembler.sv
// Pops flits from the inter-board receive FIFO and assembles them into one wide packet word.
// Optional packet/error statistics counters are built when ROUTER_PKT_STATS_EN is defined.
module router_packet_assembler #(
    parameter int FLIT_W    = router_pkg::FLIT_W,
    parameter int MAX_FLITS = 8,
    parameter int LEN_W     = $clog2(MAX_FLITS + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [FLIT_W-1:0]                 fifo_q,
    input  logic                              fifo_empty,
    output logic                              fifo_rdreq,
    output logic                              pkt_valid,
    input  logic                              pkt_ready,
    output logic [MAX_FLITS*(FLIT_W-1)-1:0]   pkt_data,
    output logic [LEN_W-1:0]                  pkt_len,
    output logic                              pkt_err
`ifdef ROUTER_PKT_STATS_EN
    ,
    output logic [15:0]                       pkt_count,
    output logic [15:0]                       err_count
`endif
);

    import router_pkg::*;

    localparam int PW = FLIT_W - 1;

    asm_state_t       state;
    logic             rd_pending;
    logic [LEN_W-1:0] cnt;
    logic             flit_tail;
    logic [PW-1:0]    flit_payload;

    assign flit_tail    = fifo_q[FLIT_W-1];
    assign flit_payload = fifo_q[PW-1:0];

    // Only one pop in flight, so the flit returned next cycle is always the one we asked for.
    assign fifo_rdreq = !reset && (state != HOLD) && !fifo_empty && !rd_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= COLLECT;
            rd_pending <= 1'b0;
            cnt        <= '0;
            pkt_data   <= '0;
            pkt_len    <= '0;
            pkt_err    <= 1'b0;
            pkt_valid  <= 1'b0;
        end else begin
            rd_pending <= fifo_rdreq;
            case (state)
                COLLECT: begin
                    if (rd_pending) begin
                        for (int i = 0; i < MAX_FLITS; i++) begin
                            if (cnt == LEN_W'(i)) begin
                                pkt_data[PW*i +: PW] <= flit_payload;
                            end
                        end
                        if (flit_tail) begin
                            pkt_len   <= cnt + LEN_W'(1);
                            pkt_valid <= 1'b1;
                            state     <= HOLD;
                        end else if (cnt == LEN_W'(MAX_FLITS - 1)) begin
                            // Buffer full without a tail: swallow the rest of this packet.
                            state <= DROP;
                        end else begin
                            cnt <= cnt + LEN_W'(1);
                        end
                    end
                end
                DROP: begin
                    if (rd_pending && flit_tail) begin
                        pkt_len   <= LEN_W'(MAX_FLITS);
                        pkt_err   <= 1'b1;
                        pkt_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (pkt_ready) begin
                        pkt_data  <= '0;
                        cnt       <= '0;
                        pkt_len   <= '0;
                        pkt_err   <= 1'b0;
                        pkt_valid <= 1'b0;
                        state     <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

`ifdef ROUTER_PKT_STATS_EN
    logic handshake;
    assign handshake = pkt_valid && pkt_ready;

    router_sat_counter u_pkt_count (
        .clk   (clk),
        .clear (reset),
        .inc   (handshake),
        .count (pkt_count)
    );

    router_sat_counter u_err_count (
        .clk   (clk),
        .clear (reset),
        .inc   (handshake && pkt_err),
        .count (err_count)
    );
`endif

endmodule

// File: tb/tb_router_packet_assembler.sv
// Directed bench for router_packet_assembler with a simple FIFO model on the read side.
module tb_router_packet_assembler;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] fifo_q;
    logic        fifo_empty;
    logic        fifo_rdreq;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [79:0] pkt_data;
    logic [3:0]  pkt_len;
    logic        pkt_err;
`ifdef ROUTER_PKT_STATS_EN
    logic [15:0] pkt_count;
    logic [15:0] err_count;
`endif

    router_packet_assembler dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_q     (fifo_q),
        .fifo_empty (fifo_empty),
        .fifo_rdreq (fifo_rdreq),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_data   (pkt_data),
        .pkt_len    (pkt_len),
        .pkt_err    (pkt_err)
`ifdef ROUTER_PKT_STATS_EN
        ,
        .pkt_count  (pkt_count),
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    // FIFO model: show-ahead-free, data appears the cycle after the pop.
    logic [10:0] mem [0:63];
    int          wp = 0;
    int          rp = 0;
    logic        hold_empty = 1'b0;
    logic        tog_en = 1'b0;
    int          tcnt = 0;

    assign fifo_empty = (wp == rp) || hold_empty;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rdreq) begin
            fifo_q <= mem[rp % 64];
            rp     <= rp + 1;
        end
        if (tog_en) begin
            if (tcnt == 2) begin
                tcnt       <= 0;
                hold_empty <= !hold_empty;
            end else begin
                tcnt <= tcnt + 1;
            end
        end else begin
            tcnt       <= 0;
            hold_empty <= 1'b0;
        end
    end

    int   last_rd = 0;
    int   lat = -1;
    int   viol = 0;
    logic pv_prev = 1'b0;

    always @(negedge clk) begin
        if (fifo_rdreq) last_rd = cyc;
        if (pkt_valid && !pv_prev) lat = cyc - last_rd;
        pv_prev = pkt_valid;
        if (fifo_rdreq && fifo_empty) viol = viol + 1;
    end

    logic [9:0] exp_slots [0:7];

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] build(input int n);
        logic [79:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i*10 +: 10] = exp_slots[i];
        return r;
    endfunction

    task automatic push(input logic [10:0] f);
        mem[wp % 64] = f;
        wp = wp + 1;
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (!pkt_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_vld"}, {79'd0, pkt_valid}, 80'd1);
    endtask

    task automatic accept(input string tag);
        @(posedge clk);
        #1 pkt_ready = 1'b1;
        @(posedge clk);
        #1 pkt_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_vld_drop"}, {79'd0, pkt_valid}, 80'd0);
    endtask

    task automatic check_pkt(input string tag, input int n, input logic err);
        wait_valid(tag);
        chk({tag, "_len"}, {76'd0, pkt_len}, 80'(n));
        chk({tag, "_err"}, {79'd0, pkt_err}, {79'd0, err});
        chk({tag, "_data"}, pkt_data, build(n));
        accept(tag);
    endtask

    initial begin
        reset     = 1'b1;
        pkt_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdreq", {79'd0, fifo_rdreq}, 80'd0);
        chk("rst_vld", {79'd0, pkt_valid}, 80'd0);
        chk("rst_len", {76'd0, pkt_len}, 80'd0);
        chk("rst_err", {79'd0, pkt_err}, 80'd0);
        chk("rst_data", pkt_data, 80'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Six-flit packet, then a single-flit packet waiting behind it.
        for (int i = 1; i <= 5; i++) push(11'(i));
        push(11'h406);
        push(11'h4AA);
        for (int i = 0; i < 6; i++) exp_slots[i] = 10'(i + 1);
        wait_valid("p6");
        chk("p6_len", {76'd0, pkt_len}, 80'd6);
        chk("p6_err", {79'd0, pkt_err}, 80'd0);
        for (int c = 0; c < 20; c++) begin
            chk("hold_rdreq", {79'd0, fifo_rdreq}, 80'd0);
            chk("hold_vld", {79'd0, pkt_valid}, 80'd1);
            chk("hold_data", pkt_data, build(6));
            @(negedge clk);
        end
        @(posedge clk);
        #1 pkt_ready = 1'b1;
        @(posedge clk);
        #1 pkt_ready = 1'b0;
        @(negedge clk);
        chk("p6_vld_drop", {79'd0, pkt_valid}, 80'd0);
        chk("resume_rdreq", {79'd0, fifo_rdreq}, 80'd1);
        chk("p6_latency", 80'(lat), 80'd2);

        exp_slots[0] = 10'h0AA;
        check_pkt("p1", 1, 1'b0);

        // Overlength: ten flits, tail on the last, then a tail-only 0x7FF.
        for (int i = 0; i < 9; i++) push(11'(8'h10 + i));
        push(11'h419);
        push(11'h7FF);
        for (int i = 0; i < 8; i++) exp_slots[i] = 10'(8'h10 + i);
        check_pkt("ovl", 8, 1'b1);
        exp_slots[0] = 10'h3FF;
        check_pkt("after_ovl", 1, 1'b0);
`ifdef ROUTER_PKT_STATS_EN
        chk("pkt_count", {64'd0, pkt_count}, 80'd4);
        chk("err_count", {64'd0, err_count}, 80'd1);
`endif

        // Empty flag toggling while a four-flit packet streams in.
        tog_en = 1'b1;
        push(11'h0A1);
        push(11'h0A2);
        push(11'h0A3);
        push(11'h4A4);
        for (int i = 0; i < 4; i++) exp_slots[i] = 10'(8'hA1 + i);
        check_pkt("tog", 4, 1'b0);
        tog_en = 1'b0;
        chk("no_rd_when_empty", 80'(viol), 80'd0);

        // Reset in the middle of a packet, then a clean three-flit packet.
        push(11'h031);
        push(11'h032);
        push(11'h033);
        begin
            int k;
            k = 0;
            while (rp != wp && k < 100) begin
                @(posedge clk);
                k++;
            end
            chk("drain_timeout", 80'(wp - rp), 80'd0);
        end
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        push(11'h041);
        push(11'h042);
        push(11'h443);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_rdreq", {79'd0, fifo_rdreq}, 80'd0);
        chk("mid_rst_vld", {79'd0, pkt_valid}, 80'd0);
        chk("mid_rst_len", {76'd0, pkt_len}, 80'd0);
        chk("mid_rst_data", pkt_data, 80'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) exp_slots[i] = 10'(8'h41 + i);
        check_pkt("post_rst", 3, 1'b0);
`ifdef ROUTER_PKT_STATS_EN
        chk("pkt_count_rst", {64'd0, pkt_count}, 80'd1);
        chk("err_count_rst", {64'd0, err_count}, 80'd0);
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
